// File: rtl/ca_code_gen.sv
// GPS L1 C/A Gold-code generator: G1/G2 LFSRs stepped per half-chip, E/P/L taps, epoch dump.
// All outputs registered, visible one clk after the strobe; no backpressure (strobe-driven by the code NCO).
module ca_code_gen #(
  parameter int          CHIPS_PER_EPOCH = 1023,
  parameter logic [9:0]  G1_INIT         = 10'h3FF
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        hc_enable,
  input  logic        prn_key_enable,
  input  logic [9:0]  prn_key,
  input  logic        slew_enable,
  input  logic [10:0] code_slew,
  output logic        early,
  output logic        prompt,
  output logic        late,
  output logic        dump_enable,
  output logic [10:0] code_phase
);

  localparam logic [9:0]  LAST_CHIP = 10'(CHIPS_PER_EPOCH - 1);
  localparam logic [10:0] LAST_HALF = 11'(2 * CHIPS_PER_EPOCH - 1);

  typedef enum logic {RUN, SLEW} state_t;

  state_t      state, state_nxt;
  logic [10:0] slew_cnt, slew_nxt;
  logic [9:0]  g1, g2, g2_key, chip_cnt;
  logic        half;
  logic        gold, g1_fb, g2_fb, slew_take, step, epoch;

  assign gold      = g1[9] ^ g2[9];
  assign g1_fb     = g1[2] ^ g1[9];
  assign g2_fb     = g2[1] ^ g2[2] ^ g2[5] ^ g2[7] ^ g2[8] ^ g2[9];
  assign slew_take = slew_enable && (code_slew != 11'd0);
  assign epoch     = step && half && (chip_cnt == LAST_CHIP);

  // A strobe coincident with a slew load is swallowed and counts as the first one.
  always_comb begin
    state_nxt = state;
    slew_nxt  = slew_cnt;
    step      = 1'b0;
    if (prn_key_enable) begin
      state_nxt = RUN;
      slew_nxt  = 11'd0;
      if (slew_take) begin
        state_nxt = SLEW;
        slew_nxt  = code_slew;
      end
    end else if (slew_take) begin
      if (hc_enable) begin
        slew_nxt  = code_slew - 11'd1;
        state_nxt = (code_slew == 11'd1) ? RUN : SLEW;
      end else begin
        slew_nxt  = code_slew;
        state_nxt = SLEW;
      end
    end else if (hc_enable) begin
      if (state == SLEW) begin
        slew_nxt = slew_cnt - 11'd1;
        if (slew_cnt == 11'd1) state_nxt = RUN;
      end else begin
        step = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= RUN;
      slew_cnt <= 11'd0;
    end else begin
      state    <= state_nxt;
      slew_cnt <= slew_nxt;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      g1          <= G1_INIT;
      g2          <= 10'h3FF;
      g2_key      <= 10'h3FF;
      chip_cnt    <= 10'd0;
      half        <= 1'b0;
      early       <= 1'b0;
      prompt      <= 1'b0;
      late        <= 1'b0;
      dump_enable <= 1'b0;
      code_phase  <= 11'd0;
    end else begin
      dump_enable <= 1'b0;
      if (prn_key_enable) begin
        g2_key     <= prn_key;
        g2         <= prn_key;
        g1         <= G1_INIT;
        chip_cnt   <= 10'd0;
        half       <= 1'b0;
        code_phase <= 11'd0;
        early      <= 1'b0;
        prompt     <= 1'b0;
        late       <= 1'b0;
      end else if (step) begin
        late   <= prompt;
        prompt <= early;
        early  <= gold;
        half   <= ~half;
        if (epoch) begin
          chip_cnt    <= 10'd0;
          g1          <= G1_INIT;
          g2          <= g2_key;
          code_phase  <= 11'd0;
          dump_enable <= 1'b1;
        end else begin
          if (half) begin
            g1       <= {g1[8:0], g1_fb};
            g2       <= {g2[8:0], g2_fb};
            chip_cnt <= chip_cnt + 10'd1;
          end
          code_phase <= (code_phase == LAST_HALF) ? 11'd0 : code_phase + 11'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ca_code_gen.sv
// Bench for ca_code_gen: randomized strobes checked against a chip-sequence model.
// The model derives codes from the Gold-code recurrences and tracks position in half-chips.
module tb_ca_code_gen;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        hc_enable = 1'b0;
  logic        prn_key_enable = 1'b0;
  logic [9:0]  prn_key = 10'd0;
  logic        slew_enable = 1'b0;
  logic [10:0] code_slew = 11'd0;
  logic        early, prompt, late, dump_enable;
  logic [10:0] code_phase;

  int tests = 0;
  int fails = 0;

  ca_code_gen dut (
    .clk(clk), .rstn(rstn), .hc_enable(hc_enable), .prn_key_enable(prn_key_enable),
    .prn_key(prn_key), .slew_enable(slew_enable), .code_slew(code_slew),
    .early(early), .prompt(prompt), .late(late), .dump_enable(dump_enable),
    .code_phase(code_phase)
  );

  always #5 clk = ~clk;

  // Reference: full chip sequences plus a half-chip position counter.
  bit g1s [1023];
  bit g2s [1023];
  int m_p;
  bit m_e, m_pr, m_l, m_dump;
  int m_slew;

  task automatic model_build(input logic [9:0] key);
    logic [9:0] g1i;
    g1i = 10'h3FF;
    for (int i = 0; i < 10; i++) begin
      g1s[i] = g1i[9-i];
      g2s[i] = key[9-i];
    end
    for (int n = 10; n < 1023; n++) begin
      g1s[n] = g1s[n-3] ^ g1s[n-10];
      g2s[n] = g2s[n-2] ^ g2s[n-3] ^ g2s[n-6] ^ g2s[n-8] ^ g2s[n-9] ^ g2s[n-10];
    end
    m_p = 0; m_e = 0; m_pr = 0; m_l = 0; m_slew = 0; m_dump = 0;
  endtask

  task automatic model_hc();
    if (m_slew > 0) begin
      m_slew--;
    end else begin
      m_l  = m_pr;
      m_pr = m_e;
      m_e  = g1s[m_p/2] ^ g2s[m_p/2];
      if (m_p == 2045) begin
        m_p = 0;
        m_dump = 1;
      end else begin
        m_p++;
      end
    end
  endtask

  // Drives one event cycle then idles one cycle; outputs are sampled at the return negedge.
  task automatic drive(input bit hc, input bit pk, input logic [9:0] key,
                       input bit se, input logic [10:0] sl);
    @(negedge clk);
    hc_enable = hc; prn_key_enable = pk; prn_key = key; slew_enable = se; code_slew = sl;
    @(negedge clk);
    hc_enable = 0; prn_key_enable = 0; slew_enable = 0;
    m_dump = 0;
    if (pk) begin
      model_build(key);
      if (se && sl != 0) m_slew = int'(sl);
    end else if (se && sl != 0) begin
      m_slew = int'(sl) - (hc ? 1 : 0);
    end else if (hc) begin
      model_hc();
    end
  endtask

  task automatic strobe();
    drive(1'b1, 1'b0, 10'd0, 1'b0, 11'd0);
  endtask

  task automatic gap();
    repeat ($urandom_range(0, 1)) @(negedge clk);
  endtask

  task automatic test_reset();
    int dumps;
    rstn = 0;
    repeat (3) @(negedge clk);
    rstn = 1;
    model_build(10'h3FF);
    @(negedge clk);
    tests++;
    if ({early, prompt, late, dump_enable, code_phase} !== 15'd0) begin
      fails++;
      $display("FAIL reset_outputs: got epl=%b%b%b dump=%b phase=%0d, want all 0",
               early, prompt, late, dump_enable, code_phase);
    end
    dumps = 0;
    repeat (100) begin
      @(negedge clk);
      if (dump_enable) dumps++;
    end
    tests++;
    if (dumps !== 0) begin
      fails++;
      $display("FAIL reset_idle_dump: got %0d dumps, want 0", dumps);
    end
  endtask

  task automatic test_prn1();
    logic [9:0] chips;
    chips = '0;
    drive(1'b0, 1'b1, 10'h0DF, 1'b0, 11'd0);
    for (int s = 1; s <= 20; s++) begin
      strobe();
      tests++;
      if ({early, prompt, late, dump_enable, code_phase} !== {m_e, m_pr, m_l, m_dump, 11'(m_p)}) begin
        fails++;
        $display("FAIL prn1_epl s=%0d: got %b%b%b d%b p%0d, want %b%b%b d%b p%0d", s,
                 early, prompt, late, dump_enable, code_phase, m_e, m_pr, m_l, m_dump, m_p);
      end
      if (s % 2 == 1) chips[9 - (s/2)] = early;
    end
    tests++;
    if (chips !== 10'b1100100000) begin
      fails++;
      $display("FAIL prn1_chips: got %b, want 1100100000", chips);
    end
  endtask

  task automatic test_epoch();
    bit ep1 [2046];
    int dumps, dump_at, bad;
    drive(1'b0, 1'b1, 10'($urandom_range(1, 1023)), 1'b0, 11'd0);
    dumps = 0; dump_at = -1; bad = 0;
    for (int s = 1; s <= 2046; s++) begin
      strobe();
      ep1[s-1] = early;
      if (dump_enable) begin dumps++; dump_at = s; end
      tests++;
      if ({early, prompt, late, dump_enable, code_phase} !== {m_e, m_pr, m_l, m_dump, 11'(m_p)}) begin
        fails++;
        $display("FAIL epoch1_model s=%0d: got %b%b%b d%b p%0d, want %b%b%b d%b p%0d", s,
                 early, prompt, late, dump_enable, code_phase, m_e, m_pr, m_l, m_dump, m_p);
      end
    end
    @(negedge clk);
    tests++;
    if (dump_enable !== 1'b0) begin
      fails++;
      $display("FAIL epoch_dump_width: dump still %b a cycle later, want 0", dump_enable);
    end
    tests++;
    if (dumps !== 1 || dump_at !== 2046) begin
      fails++;
      $display("FAIL epoch_dump_count: got %0d dumps at strobe %0d, want 1 at 2046", dumps, dump_at);
    end
    for (int s = 1; s <= 2046; s++) begin
      strobe();
      if (early !== ep1[s-1]) bad++;
      tests++;
      if ({early, prompt, late, dump_enable, code_phase} !== {m_e, m_pr, m_l, m_dump, 11'(m_p)}) begin
        fails++;
        $display("FAIL epoch2_model s=%0d: got %b%b%b d%b p%0d, want %b%b%b d%b p%0d", s,
                 early, prompt, late, dump_enable, code_phase, m_e, m_pr, m_l, m_dump, m_p);
      end
    end
    tests++;
    if (bad !== 0) begin
      fails++;
      $display("FAIL epoch_repeat: %0d chips differ between epochs, want 0", bad);
    end
  endtask

  task automatic test_slew();
    logic [10:0] ph0;
    logic        e0;
    int p0, n, dump_at;
    drive(1'b0, 1'b1, 10'($urandom_range(0, 1023)), 1'b0, 11'd0);
    repeat (600) strobe();
    p0 = m_p; ph0 = code_phase; e0 = early;
    drive(1'b0, 1'b0, 10'd0, 1'b1, 11'd5);
    for (int s = 1; s <= 5; s++) begin
      strobe();
      tests++;
      if (code_phase !== ph0 || early !== e0 || dump_enable !== 1'b0) begin
        fails++;
        $display("FAIL slew_frozen s=%0d: got p%0d e%b d%b, want p%0d e%b d0", s,
                 code_phase, early, dump_enable, ph0, e0);
      end
    end
    strobe();
    tests++;
    if (code_phase !== ph0 + 11'd1) begin
      fails++;
      $display("FAIL slew_resume: got phase %0d, want %0d", code_phase, ph0 + 11'd1);
    end
    n = 6; dump_at = -1;
    while (dump_at < 0 && n < 3000) begin
      strobe(); n++;
      if (dump_enable) dump_at = n;
    end
    tests++;
    if (dump_at !== 2046 - p0 + 5) begin
      fails++;
      $display("FAIL slew_dump_delay: dump at strobe %0d, want %0d", dump_at, 2046 - p0 + 5);
    end
    // Random slews: with/without coincident strobe, zero counts, reloads mid-slew.
    for (int k = 0; k < 8; k++) begin
      drive(1'($urandom_range(0, 1)), 1'b0, 10'd0, 1'b1, 11'($urandom_range(0, 12)));
      for (int s = 0; s < 16; s++) begin
        if (s == 4 && k[0]) drive(1'($urandom_range(0, 1)), 1'b0, 10'd0, 1'b1, 11'($urandom_range(1, 6)));
        else strobe();
        tests++;
        if ({early, prompt, late, dump_enable, code_phase} !== {m_e, m_pr, m_l, m_dump, 11'(m_p)}) begin
          fails++;
          $display("FAIL slew_rand k=%0d s=%0d: got %b%b%b d%b p%0d, want %b%b%b d%b p%0d", k, s,
                   early, prompt, late, dump_enable, code_phase, m_e, m_pr, m_l, m_dump, m_p);
        end
        gap();
      end
    end
  endtask

  task automatic test_prn_coincident();
    int dumps, dump_at;
    logic [9:0] key;
    key = 10'($urandom_range(0, 1023));
    drive(1'b0, 1'b1, key, 1'b0, 11'd0);
    repeat (1000) strobe();
    tests++;
    if (code_phase !== 11'd1000) begin
      fails++;
      $display("FAIL prn_coinc_setup: phase %0d, want 1000", code_phase);
    end
    drive(1'b1, 1'b1, key ^ 10'h155, 1'b0, 11'd0);
    tests++;
    if ({early, prompt, late, dump_enable, code_phase} !== 15'd0) begin
      fails++;
      $display("FAIL prn_coinc_clear: got %b%b%b d%b p%0d, want all 0",
               early, prompt, late, dump_enable, code_phase);
    end
    dumps = 0; dump_at = -1;
    for (int s = 1; s <= 2046; s++) begin
      strobe();
      if (dump_enable) begin dumps++; dump_at = s; end
      if (s % 97 == 0 || s == 2046) begin
        tests++;
        if ({early, prompt, late, dump_enable, code_phase} !== {m_e, m_pr, m_l, m_dump, 11'(m_p)}) begin
          fails++;
          $display("FAIL prn_coinc_model s=%0d: got %b%b%b d%b p%0d, want %b%b%b d%b p%0d", s,
                   early, prompt, late, dump_enable, code_phase, m_e, m_pr, m_l, m_dump, m_p);
        end
      end
    end
    tests++;
    if (dumps !== 1 || dump_at !== 2046) begin
      fails++;
      $display("FAIL prn_coinc_dump: %0d dumps at strobe %0d, want 1 at 2046", dumps, dump_at);
    end
  endtask

  task automatic test_reset_in_slew();
    drive(1'b0, 1'b1, 10'($urandom_range(0, 1023)), 1'b0, 11'd0);
    repeat (7) strobe();
    drive(1'b0, 1'b0, 10'd0, 1'b1, 11'd300);
    repeat (3) strobe();
    #2 rstn = 0;
    #1;
    tests++;
    if ({early, prompt, late, dump_enable, code_phase} !== 15'd0) begin
      fails++;
      $display("FAIL rst_async: got %b%b%b d%b p%0d, want all 0",
               early, prompt, late, dump_enable, code_phase);
    end
    repeat (2) @(negedge clk);
    rstn = 1;
    model_build(10'h3FF);
    for (int s = 1; s <= 4; s++) begin
      strobe();
      tests++;
      if ({early, prompt, late, dump_enable, code_phase} !== {m_e, m_pr, m_l, m_dump, 11'(m_p)}) begin
        fails++;
        $display("FAIL rst_slew_run s=%0d: got %b%b%b d%b p%0d, want %b%b%b d%b p%0d", s,
                 early, prompt, late, dump_enable, code_phase, m_e, m_pr, m_l, m_dump, m_p);
      end
    end
  endtask

  initial begin
    test_reset();
    test_prn1();
    test_epoch();
    test_slew();
    test_prn_coincident();
    test_reset_in_slew();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL timeout: bench exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
